csr_trap_ctrl: RTL
==================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 Parameter: MEPC_ALIGN_MASK, 32'hFFFF_FFFC, AND-mask applied to trap_pc before it is written to mepc.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 trap_req  in  1  exception/interrupt request, held high by requester until req_ack.
REQ-005 trap_pc / trap_cause / trap_tval  in  32 each  trap PC, mcause value, mtval value; valid while trap_req=1.
REQ-006 mret_req  in  1  mret request, held high until req_ack.
REQ-007 inst_csr_we  in  1; inst_csr_addr  in  12; inst_csr_wdata  in  32: pipeline CSR-instruction write request.
REQ-008 inst_csr_raddr  in  12  pipeline CSR read address.
REQ-009 inst_csr_ready  out  1  pipeline write accepted this cycle when inst_csr_we=1.
REQ-010 req_ack  out  1  one-cycle pulse: trap or mret accepted.
REQ-011 csr_we  out  1; csr_addr_w  out  12; csr_wdata  out  32: single CSR-file write port.
REQ-012 csr_addr_r  out  12; csr_rdata  in  32: CSR-file combinational read port.
REQ-013 redirect_valid  out  1; redirect_pc  out  32: fetch redirect.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, M_MSTATUS, M_JUMP.
REQ-016 IDLE priority: trap_req > mret_req > inst_csr_we; req_ack=1 combinationally in the IDLE cycle a trap or mret is accepted.
REQ-017 On trap acceptance, trap_pc&MEPC_ALIGN_MASK, trap_cause, trap_tval are captured into internal registers at that edge; later input changes have no effect.
REQ-018 Trap path: IDLE -> T_MEPC (write 0x341=captured pc) -> T_MCAUSE (write 0x342=captured cause) -> T_MTVAL (write 0x343=captured tval) -> T_MSTATUS -> T_JUMP -> IDLE; one cycle each.
REQ-019 T_MSTATUS: csr_addr_r=0x300; write 0x300 = rdata with bit7(MPIE)=rdata bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11; all other bits unchanged.
REQ-020 T_JUMP: csr_addr_r=0x305, csr_we=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}.
REQ-021 Mret path: IDLE -> M_MSTATUS -> M_JUMP -> IDLE; M_MSTATUS reads 0x300, writes MIE=old MPIE, MPIE=1, MPP=2'b11; M_JUMP reads 0x341, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}.
REQ-022 inst_csr_ready=1 only in IDLE with trap_req=0 and mret_req=0; then csr_we=inst_csr_we, csr_addr_w=inst_csr_addr, csr_wdata=inst_csr_wdata (writes to 0x301 are forwarded; the CSR file discards them).
REQ-023 In IDLE csr_addr_r=inst_csr_raddr; in every non-IDLE state csr_addr_r is controller-driven (0x300 in non-read states).
REQ-024 Requests arriving while busy=1 are not acknowledged; they are serviced from IDLE after the sequence completes (no back-to-back without an IDLE cycle).
REQ-025 redirect_valid is high for exactly one cycle per accepted trap/mret; csr_we=0 in T_JUMP and M_JUMP.

Reset
REQ-026 rst low: state=IDLE immediately; captured registers=0; csr_we, req_ack, redirect_valid, busy, inst_csr_ready=0, redirect_pc=0, csr_addr_w=0, csr_wdata=0 while rst low.
REQ-027 Reset mid-sequence abandons it; already-issued CSR writes are not undone, no further writes issued.

Configuration
REQ-028 Macro CSR_TRAP_MTVAL_EN: defined -> T_MTVAL state exists, trap redirect 5 cycles after acceptance edge; undefined -> T_MCAUSE goes directly to T_MSTATUS, trap_tval ignored, mtval never written, redirect 4 cycles after acceptance.

Verification
REQ-029 Reset, mstatus=0x1808, mtvec=0x170; trap_req pc=0x204, cause=0x2, tval=0xDEAD -> mepc=0x204, mcause=0x2, mtval=0xDEAD (macro on), mstatus=0x1880, redirect_pc=0x170 one cycle.
REQ-030 Then mret_req -> mstatus=0x1888, redirect_pc=0x204 on M_JUMP cycle, req_ack single pulse.
REQ-031 trap_req and inst_csr_we (0x340<=0x55) same cycle -> trap wins, inst_csr_ready=0 until IDLE, 0x340 written only after return to IDLE.
REQ-032 mret_req asserted during T_MCAUSE -> no req_ack until IDLE, then mret completes normally.
REQ-033 rst low during T_MCAUSE -> mepc written, mcause unchanged, busy=0 immediately.
REQ-034 Macro off: same trap as REQ-029 -> mtval stays 0, redirect_valid 4 cycles after acceptance edge.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer that drives a single-write-port CSR file.
// Define CSR_TRAP_MTVAL_EN to include the mtval write step (T_MTVAL).
module csr_trap_ctrl #(
  parameter logic [31:0] MEPC_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic        inst_csr_we,
  input  logic [11:0] inst_csr_addr,
  input  logic [31:0] inst_csr_wdata,
  input  logic [11:0] inst_csr_raddr,
  output logic        inst_csr_ready,
  output logic        req_ack,
  output logic        csr_we,
  output logic [11:0] csr_addr_w,
  output logic [31:0] csr_wdata,
  output logic [11:0] csr_addr_r,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, M_MSTATUS, M_JUMP
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cap_pc, cap_cause;
  logic [31:0] mstatus_trap, mstatus_mret;
  logic        trap_accept;

  assign trap_accept = (state == IDLE) && trap_req;

  // NOTE: async active-low reset lives only in the sensitivity list and the
  // first branch; all state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Trap operands are frozen at acceptance so the requester may move on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_pc    <= '0;
      cap_cause <= '0;
    end else if (trap_accept) begin
      cap_pc    <= trap_pc & MEPC_ALIGN_MASK;
      cap_cause <= trap_cause;
    end
  end

`ifdef CSR_TRAP_MTVAL_EN
  logic [31:0] cap_tval;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cap_tval <= '0;
    else if (trap_accept) cap_tval <= trap_tval;
  end
`else
  logic unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  // NOTE: combinational blocks use blocking assignments, defaults first, so
  // no path leaves a variable unassigned (no latches).
  always_comb begin
    mstatus_trap        = csr_rdata;
    mstatus_trap[7]     = csr_rdata[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = csr_rdata;
    mstatus_mret[3]     = csr_rdata[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  always_comb begin
    state_nx       = state;
    inst_csr_ready = 1'b0;
    req_ack        = 1'b0;
    csr_we         = 1'b0;
    csr_addr_w     = '0;
    csr_wdata      = '0;
    csr_addr_r     = ADDR_MSTATUS;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state)
      IDLE: begin
        csr_addr_r = inst_csr_raddr;
        if (trap_req) begin
          req_ack  = 1'b1;
          state_nx = T_MEPC;
        end else if (mret_req) begin
          req_ack  = 1'b1;
          state_nx = M_MSTATUS;
        end else begin
          inst_csr_ready = 1'b1;
          csr_we         = inst_csr_we;
          csr_addr_w     = inst_csr_addr;
          csr_wdata      = inst_csr_wdata;
        end
      end
      T_MEPC: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MEPC;
        csr_wdata  = cap_pc;
        state_nx   = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MCAUSE;
        csr_wdata  = cap_cause;
`ifdef CSR_TRAP_MTVAL_EN
        state_nx   = T_MTVAL;
`else
        state_nx   = T_MSTATUS;
`endif
      end
`ifdef CSR_TRAP_MTVAL_EN
      T_MTVAL: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MTVAL;
        csr_wdata  = cap_tval;
        state_nx   = T_MSTATUS;
      end
`endif
      T_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MSTATUS;
        csr_wdata  = mstatus_trap;
        state_nx   = T_JUMP;
      end
      T_JUMP: begin
        csr_addr_r     = ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_nx       = IDLE;
      end
      M_MSTATUS: begin
        csr_we     = 1'b1;
        csr_addr_w = ADDR_MSTATUS;
        csr_wdata  = mstatus_mret;
        state_nx   = M_JUMP;
      end
      M_JUMP: begin
        csr_addr_r     = ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // IDLE forwards pipeline inputs, so outputs must be forced quiet in reset.
    if (!rst) begin
      inst_csr_ready = 1'b0;
      req_ack        = 1'b0;
      csr_we         = 1'b0;
      csr_addr_w     = '0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  assign busy = (state != IDLE);

endmodule
